// File: rtl/d_flip_flop_with_preset_pkg.sv
// Shared constants for the preset-loadable D register.
//   DefaultWidth : width used when an instance does not override WIDTH;
//                  one bit is the per-stage cell of a shift chain.
package d_flip_flop_with_preset_pkg;

  localparam int unsigned DefaultWidth = 1;

endpackage

// File: rtl/d_flip_flop_with_preset.sv
// Enable-gated D register whose reset loads a caller-supplied preset value.
// Leaf storage cell for preset-loadable shift chains, or a register bank
// when WIDTH > 1. All bits share Clk, En and Reset and are fully independent.
//
// Ports:
//   Clk    in   1      rising-edge clock
//   Reset  in   1      asynchronous, active-high; loads Preset into Q
//   En     in   1      clock enable, active-high
//   Preset in   WIDTH  value loaded into Q while Reset is asserted
//   D      in   WIDTH  data captured on a Clk rising edge when En=1
//   Q      out  WIDTH  registered state
module d_flip_flop_with_preset
  import d_flip_flop_with_preset_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] Preset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Hold unless enabled; reset is handled in the flop itself.
  always_comb begin
    q_d = q_q;
    if (En) begin
      q_d = D;
    end
  end

  // Reset has priority over En. The rising edge of Reset loads Preset at once;
  // while Reset stays high, every Clk edge reloads Preset so changes to it
  // propagate one edge later.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_q <= Preset;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_d_flip_flop_with_preset.sv
// Free-running 100 MHz clock source: starts low, first rising edge at 5 ns.
module clock_100 (
  output logic Clk
);
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
endmodule

// Directed bench: single-bit cell on a hand-pulsed clock, an 8-bit bank,
// and a 64-stage, 3-bit-stride shift chain clocked by clock_100.
module tb_d_flip_flop_with_preset;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- single-bit cell and 8-bit bank, manual clock ----------
  logic       clk;
  logic       rst;
  logic       en;
  logic [0:0] preset;
  logic [0:0] d;
  logic [0:0] q;
  logic [7:0] bank_preset;
  logic [7:0] bank_d;
  logic [7:0] bank_q;

  d_flip_flop_with_preset u_cell (
    .Clk    (clk),
    .Reset  (rst),
    .En     (en),
    .Preset (preset),
    .D      (d),
    .Q      (q)
  );

  d_flip_flop_with_preset #(
    .WIDTH (8)
  ) u_bank (
    .Clk    (clk),
    .Reset  (rst),
    .En     (en),
    .Preset (bank_preset),
    .D      (bank_d),
    .Q      (bank_q)
  );

  task automatic pulse();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  // ---------------- 64-stage chain ------------------------------------------
  logic        chain_clk;
  logic        chain_rst;
  logic        chain_en;
  logic [63:0] chain_in;
  logic [63:0] chain_out;

  clock_100 u_clk (
    .Clk (chain_clk)
  );

  for (genvar i = 0; i < 64; i++) begin : g_stage
    if (i < 3) begin : g_head
      d_flip_flop_with_preset u_ff (
        .Clk    (chain_clk),
        .Reset  (chain_rst),
        .En     (chain_en),
        .Preset (chain_in[i]),
        .D      (1'b0),
        .Q      (chain_out[i])
      );
    end else begin : g_body
      d_flip_flop_with_preset u_ff (
        .Clk    (chain_clk),
        .Reset  (chain_rst),
        .En     (chain_en),
        .Preset (chain_in[i]),
        .D      (chain_out[i-3]),
        .Q      (chain_out[i])
      );
    end
  end

  // ---------------- stimulus -------------------------------------------------
  logic [0:0] toggle_pat [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [0:0] prev_d;

  initial begin
    clk         = 1'b0;
    rst         = 1'b0;
    en          = 1'b0;
    preset      = 1'b1;
    d           = 1'b0;
    bank_preset = 8'hA5;
    bank_d      = 8'h00;
    chain_rst   = 1'b0;
    chain_en    = 1'b0;
    chain_in    = 64'h3;
    #1;
    chain_rst = 1'b1;

    // 1. Async preset with the clock stopped low.
    #2;
    rst = 1'b1;
    #1;
    check("async_preset_1", 64'(q), 64'h1);
    check("async_bank_a5", 64'(bank_q), 64'hA5);
    rst    = 1'b0;
    preset = 1'b0;
    bank_preset = 8'h3C;
    #2;
    check("hold_no_clk", 64'(q), 64'h1);
    rst = 1'b1;
    #1;
    check("async_preset_0", 64'(q), 64'h0);
    check("async_bank_3c", 64'(bank_q), 64'h3C);

    // 2. Reset overrides enable; preset changes land on the next edge.
    en     = 1'b1;
    d      = 1'b1;
    bank_d = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      pulse();
      check("rst_priority", 64'(q), 64'h0);
    end
    check("rst_priority_bank", 64'(bank_q), 64'h3C);
    preset      = 1'b1;
    bank_preset = 8'h81;
    #1;
    check("preset_wait_edge", 64'(q), 64'h0);
    pulse();
    check("preset_on_edge", 64'(q), 64'h1);
    check("preset_on_edge_bank", 64'(bank_q), 64'h81);

    // 3. Load and hold.
    preset = 1'b0;
    pulse();
    check("rst_reload_0", 64'(q), 64'h0);
    rst    = 1'b0;
    d      = 1'b1;
    bank_d = 8'h5A;
    pulse();
    check("load_d1", 64'(q), 64'h1);
    check("load_bank", 64'(bank_q), 64'h5A);
    en     = 1'b0;
    d      = 1'b0;
    bank_d = 8'h00;
    for (int i = 0; i < 5; i++) begin
      pulse();
      check("hold_en0", 64'(q), 64'h1);
    end
    check("hold_bank", 64'(bank_q), 64'h5A);

    // 4. One-cycle capture latency with D toggling.
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d      = toggle_pat[i];
      prev_d = toggle_pat[i];
      pulse();
      check("latency", 64'(q), 64'(prev_d));
    end

    // 5. Chain shift.
    #100;
    @(negedge chain_clk);
    check("chain_preset", chain_out, 64'h3);
    chain_in  = 64'h0;
    chain_rst = 1'b0;
    chain_en  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge chain_clk);
      check("chain_shift", chain_out, 64'd3 << (3 * k));
      if (k == 4) begin
        chain_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge chain_clk);
          check("chain_freeze", chain_out, 64'h3000);
        end
        chain_en = 1'b1;
      end
    end
    @(negedge chain_clk);
    check("chain_edge21", chain_out, 64'h8000_0000_0000_0000);
    @(negedge chain_clk);
    check("chain_edge22", chain_out, 64'h0);

    // 6. Reset mid-shift while the clock is low.
    chain_in  = 64'h3;
    chain_rst = 1'b1;
    @(negedge chain_clk);
    check("chain_rearm", chain_out, 64'h3);
    chain_in  = 64'h0;
    chain_rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge chain_clk);
    end
    check("chain_k4", chain_out, 64'h3000);
    #2;
    chain_in  = 64'h5;
    chain_rst = 1'b1;
    #1;
    check("chain_async_mid", chain_out, 64'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
